// File: rtl/zeroheti_uart_rx.sv
// zeroHETI UART receiver: 16x oversampled 8N1 frames into a first-word fall-through FIFO.
// Define ZEROHETI_UART_RX_PARITY_EN to add a parity bit (parity_odd_i/parity_err_o).
module zeroheti_uart_rx #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [DIV_W-1:0]            clk_div_i,
  input  logic                        rx_i,
`ifdef ZEROHETI_UART_RX_PARITY_EN
  input  logic                        parity_odd_i,
  output logic                        parity_err_o,
`endif
  output logic [7:0]                  data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  output logic                        busy_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StGuard} state_e;

  state_e           r_state;
  logic             r_rx_meta, r_rx_s, r_rx_prev;
  logic [DIV_W-1:0] r_tick_cnt, r_div_m1;
  logic [3:0]       r_os;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_par_bad;
  logic             r_frame_err;
  logic             r_par_err;
  logic             r_overrun;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]  r_wptr, r_rptr;
  logic [CntW-1:0]  r_count;

  logic [DIV_W-1:0] w_div_m1;
  logic             w_tick, w_fall, w_sample, w_push, w_pop, w_full, w_wr, w_ovr;
  logic             w_par_bad;

  // A divider of 0 behaves like 1: a tick every cycle.
  assign w_div_m1 = (clk_div_i == '0) ? '0 : clk_div_i - 1'b1;
  assign w_tick   = (r_tick_cnt >= r_div_m1);
  assign w_fall   = r_rx_prev & ~r_rx_s;
  assign w_sample = w_tick & (r_os == 4'hF);
  assign w_push   = (r_state == StStop) & w_sample & r_rx_s & ~r_par_bad;

`ifdef ZEROHETI_UART_RX_PARITY_EN
  assign w_par_bad    = ((^r_shift) ^ r_rx_s) != parity_odd_i;
  assign parity_err_o = r_par_err;
`else
  assign w_par_bad    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StIdle;
      r_tick_cnt  <= '0;
      r_div_m1    <= '0;
      r_os        <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_par_bad   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
      if (r_state == StIdle || w_tick) r_div_m1 <= w_div_m1;
      if (r_state == StIdle || w_tick) r_tick_cnt <= '0;
      else                             r_tick_cnt <= r_tick_cnt + 1'b1;

      case (r_state)
        StIdle: begin
          if (w_fall) begin
            r_state   <= StStart;
            r_os      <= '0;
            r_par_bad <= 1'b0;
          end
        end
        StStart: begin
          if (w_tick) begin
            if (r_os == 4'd7) begin
              r_os <= '0;
              if (r_rx_s) begin
                r_state <= StIdle;
              end else begin
                r_state <= StData;
                r_bit   <= '0;
              end
            end else begin
              r_os <= r_os + 1'b1;
            end
          end
        end
        StData: begin
          if (w_tick) r_os <= r_os + 1'b1;
          if (w_sample) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
`ifdef ZEROHETI_UART_RX_PARITY_EN
            if (r_bit == 3'd7) r_state <= StParity;
`else
            if (r_bit == 3'd7) r_state <= StStop;
`endif
          end
        end
`ifdef ZEROHETI_UART_RX_PARITY_EN
        StParity: begin
          if (w_tick) r_os <= r_os + 1'b1;
          if (w_sample) begin
            r_par_bad <= w_par_bad;
            r_par_err <= w_par_bad;
            r_state   <= StStop;
          end
        end
`endif
        StStop: begin
          if (w_tick) r_os <= r_os + 1'b1;
          if (w_sample) begin
            if (r_rx_s) begin
              r_state <= StIdle;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StGuard;
            end
          end
        end
        // A held-low line (break) parks here so it cannot be taken for a new start bit.
        StGuard: begin
          if (r_rx_s) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign valid_o = (r_count != '0);
  assign w_pop   = valid_o & ready_i;
  assign w_full  = (r_count == Full);
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_ovr   = w_push & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr] <= r_shift;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_ovr;
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign data_o      = valid_o ? r_mem[r_rptr] : 8'h00;
  assign count_o     = r_count;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
  assign busy_o      = (r_state != StIdle);

endmodule

// File: tb/tb_zeroheti_uart_rx.sv
// Self-checking bench for zeroheti_uart_rx: vector table, hand-written corner cases and
// randomized frames checked against a queue model of the receive FIFO.
module tb_zeroheti_uart_rx;

  localparam int unsigned DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [15:0] clk_div_i;
  logic        rx_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic [3:0]  count_o;
  logic        frame_err_o;
  logic        overrun_o;
  logic        busy_o;
`ifdef ZEROHETI_UART_RX_PARITY_EN
  logic        parity_odd_i;
  logic        parity_err_o;
  localparam int PushOfs = 671;
`else
  localparam int PushOfs = 607;
`endif

  zeroheti_uart_rx #(.DIV_W(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clk_div_i   (clk_div_i),
    .rx_i        (rx_i),
`ifdef ZEROHETI_UART_RX_PARITY_EN
    .parity_odd_i(parity_odd_i),
    .parity_err_o(parity_err_o),
`endif
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .count_o     (count_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_perr = 0;

  always @(negedge clk_i) begin
    if (frame_err_o) n_ferr++;
    if (overrun_o) n_ovr++;
`ifdef ZEROHETI_UART_RX_PARITY_EN
    if (parity_err_o) n_perr++;
`endif
  end

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    logic [15:0] div;
    int          exp_cnt;
    int          exp_ferr;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] model_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bit_cycles();
    return 16 * ((clk_div_i == 16'd0) ? 1 : int'(clk_div_i));
  endfunction

  task automatic send_bit(input logic b, input int n);
    rx_i = b;
    repeat (n) @(negedge clk_i);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok,
                            input int idle_bits);
    int bc;
    bc = bit_cycles();
    send_bit(1'b0, bc);
    for (int i = 0; i < 8; i++) send_bit(d[i], bc);
`ifdef ZEROHETI_UART_RX_PARITY_EN
    send_bit((^d) ^ parity_odd_i ^ ~par_ok, bc);
`endif
    send_bit(stop, bc);
    if (!stop) send_bit(1'b0, 5 * bc);
    send_bit(1'b1, idle_bits * bc);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    int t;
    t = 0;
    while (!valid_o && t < 4000) begin
      @(negedge clk_i);
      t++;
    end
    chk({name, " valid"}, int'(valid_o), 1);
    chk({name, " data"}, int'(data_o), int'(exp));
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, " data_o"}, int'(data_o), 0);
    chk({name, " valid_o"}, int'(valid_o), 0);
    chk({name, " count_o"}, int'(count_o), 0);
    chk({name, " frame_err_o"}, int'(frame_err_o), 0);
    chk({name, " overrun_o"}, int'(overrun_o), 0);
    chk({name, " busy_o"}, int'(busy_o), 0);
  endtask

  initial begin
    int f0, o0, t;
    logic [7:0] d;
    logic s;

    rst_ni = 1'b0;
    rx_i = 1'b1;
    ready_i = 1'b0;
    clk_div_i = 16'd4;
`ifdef ZEROHETI_UART_RX_PARITY_EN
    parity_odd_i = 1'b0;
`endif
    repeat (4) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);

    tbl[0] = '{8'hA5, 1'b1, 16'd4, 1, 0};
    tbl[1] = '{8'h3C, 1'b0, 16'd4, 0, 1};
    tbl[2] = '{8'hFF, 1'b1, 16'd2, 1, 0};
    tbl[3] = '{8'h00, 1'b1, 16'd0, 1, 0};
    tbl[4] = '{8'h5A, 1'b0, 16'd3, 0, 1};
    tbl[5] = '{8'h81, 1'b1, 16'd1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      clk_div_i = tbl[i].div;
      f0 = n_ferr;
      o0 = n_ovr;
      send_frame(tbl[i].data, tbl[i].stop, 1'b1, 2);
      chk($sformatf("vec%0d count", i), int'(count_o), tbl[i].exp_cnt);
      chk($sformatf("vec%0d frame_err", i), n_ferr - f0, tbl[i].exp_ferr);
      chk($sformatf("vec%0d overrun", i), n_ovr - o0, 0);
      chk($sformatf("vec%0d busy", i), int'(busy_o), 0);
      if (tbl[i].exp_cnt == 1) pop_check($sformatf("vec%0d pop", i), tbl[i].data);
    end

    // Short low glitch must be rejected at the start-bit midpoint.
    clk_div_i = 16'd4;
    f0 = n_ferr;
    send_bit(1'b0, 20);
    send_bit(1'b1, 128);
    chk("glitch count", int'(count_o), 0);
    chk("glitch frame_err", n_ferr - f0, 0);
    chk("glitch busy", int'(busy_o), 0);

    // Nine bytes into an eight-entry FIFO with no consumer.
    o0 = n_ovr;
    for (int i = 0; i <= DEPTH; i++) send_frame(8'(i), 1'b1, 1'b1, 1);
    chk("overrun count", int'(count_o), DEPTH);
    chk("overrun pulses", n_ovr - o0, 1);
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("overrun pop%0d", i), 8'(i));
    chk("overrun drained", int'(count_o), 0);

    // Full FIFO: pop exactly in the push cycle of 0x55.
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b1, 1);
    chk("full count", int'(count_o), DEPTH);
    o0 = n_ovr;
    fork
      send_frame(8'h55, 1'b1, 1'b1, 2);
      begin
        t = 0;
        while (!busy_o && t < 200) begin
          @(negedge clk_i);
          t++;
        end
        repeat (PushOfs) @(negedge clk_i);
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
      end
    join
    chk("push+pop busy seen", int'(t < 200), 1);
    chk("push+pop overrun", n_ovr - o0, 0);
    chk("push+pop count", int'(count_o), DEPTH);
    for (int i = 1; i < DEPTH; i++) pop_check($sformatf("full pop%0d", i), 8'h10 + 8'(i));
    pop_check("full pop last", 8'h55);

`ifdef ZEROHETI_UART_RX_PARITY_EN
    parity_odd_i = 1'b0;
    f0 = n_perr;
    send_frame(8'h07, 1'b1, 1'b1, 2);
    chk("parity ok count", int'(count_o), 1);
    chk("parity ok perr", n_perr - f0, 0);
    pop_check("parity ok pop", 8'h07);
    send_frame(8'h07, 1'b1, 1'b0, 2);
    chk("parity bad count", int'(count_o), 0);
    chk("parity bad perr", n_perr - f0, 1);
`endif

    // Reset during data bit 4 flushes the FIFO and the partial frame.
    send_frame(8'hA5, 1'b1, 1'b1, 1);
    chk("prefill count", int'(count_o), 1);
    d = 8'h3C;
    send_bit(1'b0, 64);
    for (int i = 0; i < 4; i++) send_bit(d[i], 64);
    send_bit(d[4], 32);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset_outputs("midframe reset");
    rx_i = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    send_bit(1'b1, 128);
    send_frame(8'h81, 1'b1, 1'b1, 2);
    chk("post-reset count", int'(count_o), 1);
    pop_check("post-reset pop", 8'h81);

    // Randomized frames against a queue model; drained every four frames.
    model_q.delete();
    for (int i = 0; i < 16; i++) begin
      clk_div_i = 16'($urandom_range(0, 3));
`ifdef ZEROHETI_UART_RX_PARITY_EN
      parity_odd_i = 1'($urandom_range(0, 1));
`endif
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      f0 = n_ferr;
      send_frame(d, s, 1'b1, 1);
      if (s) model_q.push_back(d);
      chk($sformatf("rand%0d count", i), int'(count_o), model_q.size());
      chk($sformatf("rand%0d frame_err", i), n_ferr - f0, s ? 0 : 1);
      if (i % 4 == 3) begin
        while (model_q.size() > 0) pop_check($sformatf("rand%0d pop", i), model_q.pop_front());
        chk($sformatf("rand%0d drained", i), int'(count_o), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
